testdrive_apb_register_bank: RTL and testbench

APB completer: an APB master (testbench bus-functional driver or CPU bridge) reads and writes a bank of 32-bit registers over APB. Each read-write register is exported flat to user logic. Read-only slots return user-supplied status words. The block inserts a programmable number of wait states and flags address and protection errors on PSLVERR.

---
 rtl/testdrive_apb_pkg.sv | 15 +
 rtl/testdrive_apb_reg_word.sv | 16 +
 rtl/testdrive_apb_register_bank.sv | 115 +++++++++++
 tb/tb_testdrive_apb_register_bank.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/testdrive_apb_pkg.sv
// testdrive_apb_pkg: shared types, widths and the byte-strobe merge helper for the APB register bank.
package testdrive_apb_pkg;
  localparam int DWORD = 32;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  function automatic logic [DWORD-1:0] strb_merge(
    input logic [DWORD-1:0] old_v,
    input logic [DWORD-1:0] new_v,
    input logic [3:0]       strb
  );
    logic [DWORD-1:0] r;
    for (int b = 0; b < 4; b++) r[b*8+:8] = strb[b] ? new_v[b*8+:8] : old_v[b*8+:8];
    return r;
  endfunction
endpackage

// File: rtl/testdrive_apb_reg_word.sv
// testdrive_apb_reg_word: one 32-bit register with byte-strobe write and synchronous active-low reset.
module testdrive_apb_reg_word
  import testdrive_apb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [3:0]       strb_i,
  input  logic [DWORD-1:0] wdata_i,
  output logic [DWORD-1:0] data_o
);
  always_ff @(posedge clk_i) begin
    if (!rst_ni) data_o <= '0;
    else if (we_i) data_o <= strb_merge(data_o, wdata_i, strb_i);
  end
endmodule

// File: rtl/testdrive_apb_register_bank.sv
// testdrive_apb_register_bank: APB completer over a bank of 32-bit registers with wait states,
// read-only status slots and PSLVERR on bad index or read-only write.
module testdrive_apb_register_bank
  import testdrive_apb_pkg::*;
#(
  parameter int          C_ADDR_BITS   = 10,
  parameter int          C_REG_COUNT   = 16,
  parameter int          C_WAIT_CYCLES = 0,
  parameter logic [31:0] C_RO_MASK     = 32'h0
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [C_ADDR_BITS-1:0]       PADDR,
  input  logic [DWORD-1:0]             PWDATA,
  input  logic [3:0]                   PSTRB,
  output logic [DWORD-1:0]             PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  output logic [C_REG_COUNT*DWORD-1:0] REG_DATA,
  input  logic [C_REG_COUNT*DWORD-1:0] RO_DATA,
  output logic [C_REG_COUNT-1:0]       WR_PULSE,
  output logic [C_REG_COUNT-1:0]       RD_PULSE
);
  localparam int IW = C_ADDR_BITS - 2;
  localparam logic [C_REG_COUNT-1:0] RO_M = C_REG_COUNT'(C_RO_MASK);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic wr_q, pready_q, pslverr_q;
  logic [IW-1:0] idx_q, c_idx;
  logic [DWORD-1:0] wdata_q, c_wdata, prdata_q, prdata_d, rd_sel;
  logic [3:0] strb_q, c_strb;
  logic setup, in_idle, commit, c_wr, ro, err;
  logic [C_REG_COUNT-1:0] sel, wp_q, wp_d, rp_q, rp_d;
  // A zero-wait transfer commits on its setup edge, so commit fields bypass the latches in S_IDLE.
  always_comb begin
    setup    = PSEL & ~PENABLE;
    in_idle  = state_q == S_IDLE;
    c_wr     = in_idle ? PWRITE : wr_q;
    c_idx    = in_idle ? PADDR[C_ADDR_BITS-1:2] : idx_q;
    c_wdata  = in_idle ? PWDATA : wdata_q;
    c_strb   = in_idle ? PSTRB : strb_q;
    commit   = in_idle ? setup && (C_WAIT_CYCLES == 0) : state_q == S_WAIT && PSEL && cnt_q == '0;
    sel      = C_REG_COUNT'(1) << c_idx;
    ro       = |(sel & RO_M);
    err      = ~|sel | (c_wr & ro);
    rd_sel   = '0;
    for (int i = 0; i < C_REG_COUNT; i++)
      rd_sel |= sel[i] ? (RO_M[i] ? RO_DATA[i*DWORD+:DWORD] : REG_DATA[i*DWORD+:DWORD]) : '0;
    wp_d     = commit && c_wr && !err ? sel : '0;
    rp_d     = commit && !c_wr && !err ? sel : '0;
    prdata_d = commit ? (err || c_wr ? '0 : rd_sel) : prdata_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: if (setup) begin
        state_d = C_WAIT_CYCLES == 0 ? S_RESP : S_WAIT;
        cnt_d   = CNT_W'(C_WAIT_CYCLES - 1);
      end
      S_WAIT: begin
        state_d = !PSEL ? S_IDLE : cnt_q == '0 ? S_RESP : S_WAIT;
        cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      wp_q      <= '0;
      rp_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prdata_q  <= prdata_d;
      pready_q  <= commit;
      pslverr_q <= commit && err;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (in_idle && setup) begin
      wr_q    <= PWRITE;
      idx_q   <= PADDR[C_ADDR_BITS-1:2];
      wdata_q <= PWDATA;
      strb_q  <= PSTRB;
    end
  end
  for (genvar i = 0; i < C_REG_COUNT; i++) begin : g_slot
    if (RO_M[i]) begin : g_ro
      assign REG_DATA[i*DWORD+:DWORD] = '0;
    end else begin : g_rw
      testdrive_apb_reg_word u_word (
        .clk_i  (CLK),
        .rst_ni (nRST),
        .we_i   (wp_d[i]),
        .strb_i (c_strb),
        .wdata_i(c_wdata),
        .data_o (REG_DATA[i*DWORD+:DWORD])
      );
    end
  end
  assign PRDATA   = prdata_q;
  assign PREADY   = pready_q;
  assign PSLVERR  = pslverr_q;
  assign WR_PULSE = wp_q;
  assign RD_PULSE = rp_q;
endmodule

// File: tb/tb_testdrive_apb_register_bank.sv
// tb_testdrive_apb_register_bank: two banks (zero and three wait states) driven with directed and
// random APB traffic; a scoreboard queue per bank is drained by a negedge monitor.
module tb_testdrive_apb_register_bank;
  localparam int N = 16;
  typedef struct {
    bit          wr;
    bit          err;
    int          idx;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] rdata;
  } exp_t;
  logic clk = 1'b0, nrst = 1'b0;
  logic psel [2], pen [2], pwr [2], pready [2], pslverr [2];
  logic [9:0] paddr [2];
  logic [31:0] pwdata [2], prdata [2];
  logic [3:0] pstrb [2];
  logic [N*32-1:0] regd [2], rod [2];
  logic [N-1:0] wrp [2], rdp [2];
  logic [31:0] ro_m [2];
  logic [31:0] mdl [2][N];
  exp_t q0 [$], q1 [$];
  int cyc = 0, cmp = 0, bad = 0;
  int t0 [2];
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  testdrive_apb_register_bank #(.C_ADDR_BITS(10), .C_REG_COUNT(N), .C_WAIT_CYCLES(0), .C_RO_MASK(32'h8001)) u0 (
    .CLK(clk), .nRST(nrst), .PSEL(psel[0]), .PENABLE(pen[0]), .PWRITE(pwr[0]), .PADDR(paddr[0]),
    .PWDATA(pwdata[0]), .PSTRB(pstrb[0]), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]),
    .REG_DATA(regd[0]), .RO_DATA(rod[0]), .WR_PULSE(wrp[0]), .RD_PULSE(rdp[0]));
  testdrive_apb_register_bank #(.C_ADDR_BITS(10), .C_REG_COUNT(N), .C_WAIT_CYCLES(3), .C_RO_MASK(32'h1)) u1 (
    .CLK(clk), .nRST(nrst), .PSEL(psel[1]), .PENABLE(pen[1]), .PWRITE(pwr[1]), .PADDR(paddr[1]),
    .PWDATA(pwdata[1]), .PSTRB(pstrb[1]), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]),
    .REG_DATA(regd[1]), .RO_DATA(rod[1]), .WR_PULSE(wrp[1]), .RD_PULSE(rdp[1]));

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic mon(input int d);
    exp_t e;
    logic [511:0] m;
    logic [15:0] pm;
    bit have;
    if (!nrst) begin
      for (int i = 0; i < N; i++) mdl[d][i] = '0;
      return;
    end
    if (pready[d]) begin
      have = d == 0 ? q0.size() != 0 : q1.size() != 0;
      if (!have) chk("unexpected_pready", 1, 0);
      else begin
        if (d == 0) e = q0.pop_front();
        else e = q1.pop_front();
        pm = 16'(1) << e.idx;
        chk("latency", cyc - t0[d], d == 0 ? 1 : 4);
        chk("pslverr", pslverr[d], e.err);
        chk("wr_pulse", wrp[d], e.wr && !e.err ? pm : 16'h0);
        chk("rd_pulse", rdp[d], !e.wr && !e.err ? pm : 16'h0);
        if (!e.wr) chk("prdata", prdata[d], e.rdata);
        if (e.wr && !e.err)
          for (int b = 0; b < 4; b++) if (e.strb[b]) mdl[d][e.idx][b*8+:8] = e.data[b*8+:8];
      end
    end else chk("idle_pulses", {wrp[d], rdp[d]}, 0);
    for (int i = 0; i < N; i++) m[i*32+:32] = mdl[d][i];
    chk("reg_data", regd[d], m);
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // mode: 0 normal, 1 drop PSEL in T2, 2 assert reset in T2
  task automatic xfer(input int d, input bit wr, input int idx, input logic [31:0] data,
                      input logic [3:0] strb, input int mode);
    exp_t e;
    int n;
    logic [7:0] ib;
    ib = idx[7:0];
    @(posedge clk); #1;
    psel[d] = 1'b1; pen[d] = 1'b0; pwr[d] = wr; paddr[d] = {ib, 2'($urandom)};
    pwdata[d] = data; pstrb[d] = strb; t0[d] = cyc;
    e.wr = wr; e.idx = idx; e.data = data; e.strb = strb;
    e.err = idx >= N || (wr && ro_m[d][idx]);
    e.rdata = (e.err || wr) ? 32'h0 : ro_m[d][idx] ? rod[d][idx*32+:32] : mdl[d][idx];
    if (mode == 0) begin
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    @(posedge clk); #1;
    pen[d] = 1'b1;
    if (mode != 0) begin
      @(posedge clk); #1;
      if (mode == 1) begin
        psel[d] = 1'b0; pen[d] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
      end else begin
        nrst = 1'b0;
        @(posedge clk); #1;
        psel[d] = 1'b0; pen[d] = 1'b0;
        for (int k = 0; k < 2; k++) begin
          chk("rst_outputs", {pready[k], pslverr[k], prdata[k], wrp[k], rdp[k]}, 0);
          chk("rst_reg_data", regd[k], 0);
        end
        nrst = 1'b1;
      end
      return;
    end
    n = 0;
    while (!pready[d] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 40) chk("timeout_pready", 0, 1);
  endtask

  task automatic idle(input int d, input int n);
    @(posedge clk); #1;
    psel[d] = 1'b0; pen[d] = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    ro_m[0] = 32'h8001;
    ro_m[1] = 32'h1;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 0; pen[d] = 0; pwr[d] = 0; paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
      for (int i = 0; i < N; i++) begin
        rod[d][i*32+:32] = $urandom;
        mdl[d][i] = '0;
      end
      rod[d][31:0] = 32'hCAFE0001;
      t0[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      xfer(d, 1, 2, 32'hDEADBEEF, 4'hF, 0);
      xfer(d, 0, 2, 32'h0, 4'h0, 0);
      xfer(d, 1, 2, 32'h11223344, 4'b0101, 0);
      xfer(d, 0, 2, 32'h0, 4'h0, 0);
      xfer(d, 0, 0, 32'h0, 4'h0, 0);
      xfer(d, 1, 0, 32'h12345678, 4'hF, 0);
      xfer(d, 0, 16, 32'h0, 4'h0, 0);
      xfer(d, 1, 2, 32'hFFFFFFFF, 4'h0, 0);
      xfer(d, 0, 2, 32'h0, 4'h0, 0);
      for (int t = 0; t < 80; t++) begin
        if ($urandom_range(0, 9) == 0) begin
          idle(d, $urandom_range(1, 3));
          rod[d][$urandom_range(0, N-1)*32+:32] = $urandom;
        end
        xfer(d, 1'($urandom), $urandom_range(0, 19), $urandom, 4'($urandom), 0);
      end
      idle(d, 2);
    end
    xfer(1, 1, 3, 32'hA5A5A5A5, 4'hF, 1);
    xfer(1, 0, 3, 32'h0, 4'h0, 0);
    idle(1, 2);
    xfer(1, 1, 4, 32'h5A5A5A5A, 4'hF, 2);
    idle(1, 1);
    xfer(0, 0, 2, 32'h0, 4'h0, 0);
    xfer(1, 0, 2, 32'h0, 4'h0, 0);
    idle(0, 1);
    idle(1, 3);
    if (q0.size() != 0 || q1.size() != 0) chk("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
